// File: rtl/me_pkg.sv
// Shared constants and state encoding for the motion-estimation front end.
package me_pkg;
    localparam int CUR_WORDS = 32;
    localparam int REF_WORDS = 128;
    localparam int CUR_AW    = 5;
    localparam int REF_AW    = 7;
    localparam int DATA_W    = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_RUN,
        ST_DRAIN
    } me_sched_state_t;
endpackage

// File: rtl/me_word_loader.sv
// One write-port loader: counts accepted words and registers each into the engine RAM port.
module me_word_loader #(
    parameter int DEPTH  = 32,
    parameter int AW     = 5,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clear,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              full,
    output logic              last,
    output logic [AW-1:0]     wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en
);
    localparam int CW = AW + 1;

    logic [CW-1:0] cnt;

    assign ready = en && (cnt < CW'(DEPTH));
    assign full  = (cnt == CW'(DEPTH));
    // Final word being accepted this cycle; lets the FSM leave LOAD on the same edge.
    assign last  = valid && ready && (cnt == CW'(DEPTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_en   <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (clear) begin
                cnt <= '0;
            end else if (valid && ready) begin
                wr_addr <= cnt[AW-1:0];
                wr_data <= data;
                wr_en   <= 1'b1;
                cnt     <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/me_mb_scheduler.sv
// Loads current/reference blocks into the ME engine, runs it, and repeats per macroblock.
module me_mb_scheduler #(
    parameter int DATA_W    = 64,
    parameter int CUR_WORDS = 32,
    parameter int REF_WORDS = 128,
    parameter int MB_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [MB_W-1:0]          num_mb,
    input  logic [1:0]               cfg_r,
    input  logic                     cur_valid,
    output logic                     cur_ready,
    input  logic [DATA_W-1:0]        cur_data,
    input  logic                     ref_valid,
    output logic                     ref_ready,
    input  logic [DATA_W-1:0]        ref_data,
    output logic [me_pkg::CUR_AW-1:0] address_write_cur,
    output logic [DATA_W-1:0]        data_write_cur,
    output logic                     write_enable_cur,
    output logic [me_pkg::REF_AW-1:0] address_write_ref,
    output logic [DATA_W-1:0]        data_write_ref,
    output logic                     write_enable_ref,
    output logic [1:0]               r,
    output logic                     go,
    input  logic                     done,
    output logic                     busy,
    output logic                     mb_done,
    output logic [MB_W-1:0]          mb_index,
    output logic                     all_done
);
    import me_pkg::*;

    me_sched_state_t state;
    logic [MB_W-1:0] num_mb_q;
    logic            load_en, load_clr;
    logic            cur_full, cur_last, ref_full, ref_last;

    assign load_en  = (state == ST_LOAD);
    // Counts sit at zero while idle and are rewound between macroblocks.
    assign load_clr = (state == ST_IDLE) || (state == ST_DRAIN);

    me_word_loader #(.DEPTH(CUR_WORDS), .AW(CUR_AW), .DATA_W(DATA_W)) u_cur (
        .clk(clk), .reset(reset), .en(load_en), .clear(load_clr),
        .valid(cur_valid), .data(cur_data), .ready(cur_ready),
        .full(cur_full), .last(cur_last),
        .wr_addr(address_write_cur), .wr_data(data_write_cur), .wr_en(write_enable_cur)
    );

    me_word_loader #(.DEPTH(REF_WORDS), .AW(REF_AW), .DATA_W(DATA_W)) u_ref (
        .clk(clk), .reset(reset), .en(load_en), .clear(load_clr),
        .valid(ref_valid), .data(ref_data), .ready(ref_ready),
        .full(ref_full), .last(ref_last),
        .wr_addr(address_write_ref), .wr_data(data_write_ref), .wr_en(write_enable_ref)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            num_mb_q <= '0;
            r        <= '0;
            go       <= 1'b0;
            busy     <= 1'b0;
            mb_done  <= 1'b0;
            mb_index <= '0;
            all_done <= 1'b0;
        end else begin
            mb_done  <= 1'b0;
            all_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_mb != '0) begin
                            num_mb_q <= num_mb;
                            r        <= cfg_r;
                            mb_index <= '0;
                            busy     <= 1'b1;
                            state    <= ST_LOAD;
                        end else begin
                            all_done <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if ((cur_full || cur_last) && (ref_full || ref_last))
                        state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    go    <= 1'b1;
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (done) begin
                        go      <= 1'b0;
                        mb_done <= 1'b1;
                        state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!done) begin
                        if (mb_index + MB_W'(1) == num_mb_q) begin
                            all_done <= 1'b1;
                            busy     <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            mb_index <= mb_index + MB_W'(1);
                            state    <= ST_LOAD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_me_mb_scheduler.sv
// Directed bench for me_mb_scheduler: stream feeder, write-port scoreboard, engine model.
module tb_me_mb_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_mb = '0;
    logic [1:0]  cfg_r = '0;
    logic        cur_valid = 1'b0, ref_valid = 1'b0;
    logic        cur_ready, ref_ready;
    logic [63:0] cur_data = '0, ref_data = '0;
    logic [4:0]  address_write_cur;
    logic [63:0] data_write_cur, data_write_ref;
    logic        write_enable_cur, write_enable_ref;
    logic [6:0]  address_write_ref;
    logic [1:0]  r;
    logic        go, busy, mb_done, all_done;
    logic        done = 1'b0;
    logic [15:0] mb_index;

    me_mb_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .num_mb(num_mb), .cfg_r(cfg_r),
        .cur_valid(cur_valid), .cur_ready(cur_ready), .cur_data(cur_data),
        .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_data(ref_data),
        .address_write_cur(address_write_cur), .data_write_cur(data_write_cur),
        .write_enable_cur(write_enable_cur),
        .address_write_ref(address_write_ref), .data_write_ref(data_write_ref),
        .write_enable_ref(write_enable_ref),
        .r(r), .go(go), .done(done), .busy(busy), .mb_done(mb_done),
        .mb_index(mb_index), .all_done(all_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int cur_sent = 0, ref_sent = 0, cur_lim = 32, ref_lim = 128;
    int cur_gap = 0, ref_gap = 0;
    bit feed_en = 1'b0, cur_after_ref = 1'b0;
    int mb_tb = 0;
    int last_cur_hs = 0, last_ref_hs = 0;
    int wr_cur = 0, wr_ref = 0, tot_wr = 0;
    int n_mb_done = 0, n_all_done = 0;
    int idx_q[$];
    int go_rise_cyc = 0, go_cur_wr = 0, go_ref_wr = 0;
    bit go_prev = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] cur_word(input int mb, input int i);
        return {8'hC1, mb[7:0], 16'h5A5A, i[31:0]};
    endfunction

    function automatic logic [63:0] ref_word(input int mb, input int i);
        return {8'hE2, mb[7:0], 16'hA5A5, i[31:0]};
    endfunction

    always @(posedge clk) cyc++;

    // Stream feeder: decides valid/data at the falling edge; ready is stable until the next rise.
    always @(negedge clk) begin
        if (!feed_en) begin
            cur_valid = 1'b0;
            ref_valid = 1'b0;
        end else begin
            cur_valid = (cur_sent < cur_lim) && (int'($urandom_range(99)) >= cur_gap) &&
                        !(cur_after_ref && cur_sent == 31 && ref_sent < 128);
            cur_data  = cur_word(mb_tb, cur_sent);
            if (cur_valid && cur_ready) begin
                last_cur_hs = cyc;
                cur_sent++;
            end
            ref_valid = (ref_sent < ref_lim) && (int'($urandom_range(99)) >= ref_gap);
            ref_data  = ref_word(mb_tb, ref_sent);
            if (ref_valid && ref_ready) begin
                last_ref_hs = cyc;
                ref_sent++;
            end
        end
    end

    // Write-port scoreboard and pulse bookkeeping, sampled just after the rising edge.
    always @(posedge clk) begin
        #1;
        if (write_enable_cur) begin
            chk("cur_addr", 64'(address_write_cur), 64'(wr_cur));
            chk("cur_data", data_write_cur, cur_word(mb_tb, wr_cur));
            chk("cur_lat", 64'(cyc), 64'(last_cur_hs + 1));
            wr_cur++;
            tot_wr++;
        end
        if (write_enable_ref) begin
            chk("ref_addr", 64'(address_write_ref), 64'(wr_ref));
            chk("ref_data", data_write_ref, ref_word(mb_tb, wr_ref));
            chk("ref_lat", 64'(cyc), 64'(last_ref_hs + 1));
            wr_ref++;
            tot_wr++;
        end
        if (mb_done) begin
            n_mb_done++;
            idx_q.push_back(int'(mb_index));
        end
        if (all_done) n_all_done++;
        if (go && !go_prev) begin
            go_rise_cyc = cyc;
            go_cur_wr   = wr_cur;
            go_ref_wr   = wr_ref;
        end
        go_prev = go;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic new_mb(input int m);
        mb_tb = m;
        cur_sent = 0;
        ref_sent = 0;
        wr_cur = 0;
        wr_ref = 0;
    endtask

    task automatic clr_counts();
        n_mb_done = 0;
        n_all_done = 0;
        idx_q.delete();
    endtask

    task automatic start_run(input int n, input int rr);
        start  = 1'b1;
        num_mb = 16'(n);
        cfg_r  = 2'(rr);
        tick(1);
        start  = 1'b0;
    endtask

    task automatic wait_go();
        int k = 0;
        while (!go && k < 3000) begin
            tick(1);
            k++;
        end
        chk("go_timeout", 64'(go), 64'd1);
    endtask

    // Engine model: assert done for 'hold' cycles once go is up.
    task automatic engine(input int hold, input int exp_idx);
        tick(2);
        chk("go_held", 64'(go), 64'd1);
        done = 1'b1;
        tick(1);
        chk("mb_done", 64'(mb_done), 64'd1);
        chk("mb_index", 64'(mb_index), 64'(exp_idx));
        chk("go_low", 64'(go), 64'd0);
        for (int i = 1; i < hold; i++) begin
            tick(1);
            chk("no_reload", 64'({cur_ready, ref_ready, mb_done}), 64'd0);
        end
        done = 1'b0;
        tick(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        chk("rst_outs", 64'({go, busy, mb_done, all_done, write_enable_cur, write_enable_ref,
                             cur_ready, ref_ready, r}), 64'd0);
        reset = 1'b0;
        tick(1);

        // Single macroblock, streams always valid; valid before start is held off.
        new_mb(0);
        feed_en = 1'b1;
        tick(2);
        chk("held_off", 64'({cur_ready, ref_ready}), 64'd0);
        chk("held_off_wr", 64'(tot_wr), 64'd0);
        start_run(1, 2);
        chk("busy_up", 64'(busy), 64'd1);
        wait_go();
        chk("go_lat_ref", 64'(go_rise_cyc - last_ref_hs), 64'd2);
        chk("t1_cur_cnt", 64'(wr_cur), 64'd32);
        chk("t1_ref_cnt", 64'(wr_ref), 64'd128);
        chk("t1_r", 64'(r), 64'd2);
        engine(1, 0);
        chk("t1_all_done", 64'(all_done), 64'd1);
        chk("t1_busy_drop", 64'(busy), 64'd0);
        tick(1);
        chk("t1_all_pulse", 64'(all_done), 64'd0);
        chk("t1_n_mb", 64'(n_mb_done), 64'd1);
        chk("t1_n_all", 64'(n_all_done), 64'd1);

        // Random gaps, cur stream completes last.
        clr_counts();
        new_mb(0);
        cur_gap = 85;
        ref_gap = 50;
        cur_after_ref = 1'b1;
        start_run(1, 1);
        wait_go();
        chk("go_lat_cur", 64'(go_rise_cyc - last_cur_hs), 64'd2);
        chk("t2_cur_at_go", 64'(go_cur_wr), 64'd32);
        chk("t2_ref_at_go", 64'(go_ref_wr), 64'd128);
        engine(1, 0);
        chk("t2_all_done", 64'(all_done), 64'd1);
        cur_gap = 0;
        ref_gap = 0;
        cur_after_ref = 1'b0;

        // Three macroblocks with a long done.
        clr_counts();
        new_mb(0);
        start_run(3, 3);
        for (int m = 0; m < 3; m++) begin
            wait_go();
            chk("t3_go_lat", 64'(go_rise_cyc - last_ref_hs), 64'd2);
            chk("t3_cur_cnt", 64'(wr_cur), 64'd32);
            chk("t3_ref_cnt", 64'(wr_ref), 64'd128);
            engine(4, m);
            chk("t3_all_done", 64'(all_done), (m == 2) ? 64'd1 : 64'd0);
            if (m < 2) new_mb(m + 1);
        end
        tick(1);
        chk("t3_n_mb", 64'(n_mb_done), 64'd3);
        for (int i = 0; i < 3; i++) chk("t3_idx", 64'(idx_q[i]), 64'(i));
        chk("t3_n_all", 64'(n_all_done), 64'd1);

        // Zero-macroblock run.
        begin
            int tw;
            clr_counts();
            tw = tot_wr;
            start_run(0, 1);
            chk("t4_all_done", 64'(all_done), 64'd1);
            chk("t4_busy", 64'(busy), 64'd0);
            tick(1);
            chk("t4_all_pulse", 64'(all_done), 64'd0);
            tick(5);
            chk("t4_no_wr", 64'(tot_wr), 64'(tw));
            chk("t4_go", 64'(go), 64'd0);
            chk("t4_n_all", 64'(n_all_done), 64'd1);
        end

        // Restart and cfg change mid-run are ignored.
        clr_counts();
        new_mb(0);
        start_run(1, 1);
        tick(10);
        cfg_r = 2'd3;
        num_mb = 16'd5;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        chk("t5_busy", 64'(busy), 64'd1);
        wait_go();
        chk("t5_r", 64'(r), 64'd1);
        engine(1, 0);
        chk("t5_all_done", 64'(all_done), 64'd1);
        chk("t5_r_after", 64'(r), 64'd1);
        chk("t5_n_mb", 64'(n_mb_done), 64'd1);

        // Reset during LOAD with ten current words written.
        clr_counts();
        new_mb(0);
        cur_lim = 10;
        start_run(1, 2);
        begin
            int k = 0;
            while (cur_sent < 10 && k < 500) begin
                tick(1);
                k++;
            end
        end
        tick(2);
        chk("t6_pre_wr", 64'(wr_cur), 64'd10);
        reset = 1'b1;
        #1;
        chk("t6_rst_ctl", 64'({go, busy, mb_done, all_done, write_enable_cur, write_enable_ref,
                               cur_ready, ref_ready, r}), 64'd0);
        chk("t6_rst_addr", 64'({address_write_cur, address_write_ref, mb_index}), 64'd0);
        chk("t6_rst_data", data_write_cur | data_write_ref, 64'd0);
        tick(1);
        reset = 1'b0;
        cur_lim = 32;
        new_mb(0);
        tick(1);
        start_run(1, 3);
        wait_go();
        chk("t6_cur_cnt", 64'(wr_cur), 64'd32);
        chk("t6_ref_cnt", 64'(wr_ref), 64'd128);
        chk("t6_r", 64'(r), 64'd3);
        engine(1, 0);
        chk("t6_all_done", 64'(all_done), 64'd1);

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
